// File: rtl/bus_cycle_unit.sv
// 8080/8085-style bus cycle unit: runs T1/T2/T3 machine cycles with
// READY wait states for opcode fetch, memory and I/O transfers.
module bus_cycle_unit #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int MAX_BYTES  = 2,
    parameter int WAIT_LIMIT = 0
) (
    input  logic                          clock,
    input  logic                          reset_in_n,
    input  logic                          req,
    input  logic [2:0]                    req_type,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [$clog2(MAX_BYTES):0]    req_count,
    input  logic [MAX_BYTES*DATA_W-1:0]   req_wdata,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [MAX_BYTES*DATA_W-1:0]   rdata,
    input  logic [DATA_W-1:0]             DATA_in,
    output logic [DATA_W-1:0]             DATA_out,
    output logic                          DATA_oe,
    input  logic                          READY,
    output logic [ADDR_W-1:0]             ADD,
    output logic                          S0,
    output logic                          S1,
    output logic                          IO_Mn,
    output logic                          RDn,
    output logic                          WRn
);

    localparam int CNT_W  = $clog2(MAX_BYTES) + 1;
    localparam int WAIT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 8;
    localparam int BUS_W  = MAX_BYTES * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_END
    } state_t;

    state_t r_state;
    state_t w_state;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] w_base;
    logic [BUS_W-1:0]  r_wdata;
    logic [BUS_W-1:0]  w_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  w_idx;
    logic [CNT_W-1:0]  w_idx_inc;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait;
    logic [WAIT_W-1:0] w_wait_inc;
    logic              r_wr;
    logic              w_wr;
    logic              r_io;
    logic              w_io;
    logic              r_fetch;
    logic              w_fetch;
    logic              r_err;
    logic              w_err;
    logic [BUS_W-1:0]  r_rdata;
    logic [BUS_W-1:0]  w_rdata;

    logic              w_req_wr;
    logic              w_req_io;
    logic              w_req_fetch;
    logic [CNT_W-1:0]  w_req_cnt;
    logic              w_timeout;
    logic              w_cyc;
    logic              w_strb;

    logic [ADDR_W-1:0] r_add;
    logic              r_s0;
    logic              r_s1;
    logic              r_io_m;
    logic              r_rd_n;
    logic              r_wr_n;
    logic              r_oe;
    logic [DATA_W-1:0] r_dout;
    logic              r_busy;
    logic              r_done;

    function automatic logic [DATA_W-1:0] f_byte(
        input logic [BUS_W-1:0] v,
        input logic [CNT_W-1:0] i
    );
        logic [DATA_W-1:0] b;
        b = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (i == CNT_W'(k)) b = v[k*DATA_W +: DATA_W];
        end
        return b;
    endfunction

    // Unlisted type codes fall through to a plain memory read.
    always_comb begin
        w_req_wr    = 1'b0;
        w_req_io    = 1'b0;
        w_req_fetch = 1'b0;
        unique case (req_type)
            3'd0: w_req_fetch = 1'b1;
            3'd2: w_req_wr    = 1'b1;
            3'd3: w_req_io    = 1'b1;
            3'd4: begin
                w_req_io = 1'b1;
                w_req_wr = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_req_cnt = req_count;
        if (req_count == '0) begin
            w_req_cnt = CNT_W'(1);
        end else if (req_count > CNT_W'(MAX_BYTES)) begin
            w_req_cnt = CNT_W'(MAX_BYTES);
        end
    end

    assign w_idx_inc  = r_idx + 1'b1;
    assign w_wait_inc = r_wait + 1'b1;
    assign w_timeout  = (WAIT_LIMIT != 0) &&
                        (w_wait_inc == WAIT_W'(WAIT_LIMIT));

    always_ff @(posedge clock) begin
        if (!reset_in_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_comb begin
        w_state = r_state;
        w_base  = r_base;
        w_wdata = r_wdata;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_wait  = r_wait;
        w_wr    = r_wr;
        w_io    = r_io;
        w_fetch = r_fetch;
        w_err   = r_err;
        w_rdata = r_rdata;
        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state = S_T1;
                    w_base  = req_addr;
                    w_wdata = req_wdata;
                    w_cnt   = w_req_cnt;
                    w_idx   = '0;
                    w_wait  = '0;
                    w_wr    = w_req_wr;
                    w_io    = w_req_io;
                    w_fetch = w_req_fetch;
                    w_err   = 1'b0;
                    w_rdata = '0;
                end
            end
            S_T1: w_state = S_T2;
            S_T2: w_state = S_T3;
            S_T3: begin
                if (READY) begin
                    w_wait = '0;
                    if (!r_wr) begin
                        for (int k = 0; k < MAX_BYTES; k++) begin
                            if (r_idx == CNT_W'(k)) begin
                                w_rdata[k*DATA_W +: DATA_W] = DATA_in;
                            end
                        end
                    end
                    if (w_idx_inc < r_cnt) begin
                        w_idx   = w_idx_inc;
                        w_state = S_T1;
                    end else begin
                        w_state = S_END;
                    end
                end else if (w_timeout) begin
                    // Abandon the rest of the burst; captured bytes stay.
                    w_wait  = '0;
                    w_err   = 1'b1;
                    w_state = S_END;
                end else begin
                    w_wait = w_wait_inc;
                end
            end
            S_END:   w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    // Bus pins are registered from the state being entered.
    always_comb begin
        w_cyc  = (w_state == S_T1) || (w_state == S_T2) ||
                 (w_state == S_T3);
        w_strb = (w_state == S_T2) || (w_state == S_T3);
    end

    always_ff @(posedge clock) begin
        if (!reset_in_n) begin
            r_base  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wait  <= '0;
            r_wr    <= 1'b0;
            r_io    <= 1'b0;
            r_fetch <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_base  <= w_base;
            r_wdata <= w_wdata;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_wait  <= w_wait;
            r_wr    <= w_wr;
            r_io    <= w_io;
            r_fetch <= w_fetch;
            r_err   <= w_err;
            r_rdata <= w_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_in_n) begin
            r_add  <= '0;
            r_s0   <= 1'b0;
            r_s1   <= 1'b0;
            r_io_m <= 1'b0;
            r_rd_n <= 1'b1;
            r_wr_n <= 1'b1;
            r_oe   <= 1'b0;
            r_dout <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_cyc) begin
                r_add <= w_base + ADDR_W'(w_idx);
            end
            if (w_cyc && w_wr) begin
                r_dout <= f_byte(w_wdata, w_idx);
            end
            r_s1   <= w_cyc && !w_wr;
            r_s0   <= w_cyc && (w_fetch || w_wr);
            r_io_m <= w_cyc && w_io;
            r_rd_n <= !(w_strb && !w_wr);
            r_wr_n <= !(w_strb && w_wr);
            r_oe   <= w_cyc && w_wr;
            r_busy <= (w_state != S_IDLE);
            r_done <= (w_state == S_END);
        end
    end

    assign ADD      = r_add;
    assign S0       = r_s0;
    assign S1       = r_s1;
    assign IO_Mn    = r_io_m;
    assign RDn      = r_rd_n;
    assign WRn      = r_wr_n;
    assign DATA_oe  = r_oe;
    assign DATA_out = r_dout;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign rdata    = r_rdata;

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Bench for bus_cycle_unit: directed and random transfers checked
// cycle by cycle against an expanded machine-cycle timeline.
module tb_bus_cycle_unit;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int MB = 2;
    localparam int WL = 4;
    localparam int CW = $clog2(MB) + 1;

    logic             clock = 1'b0;
    logic             reset_in_n = 1'b0;
    logic             req = 1'b0;
    logic [2:0]       req_type = '0;
    logic [AW-1:0]    req_addr = '0;
    logic [CW-1:0]    req_count = '0;
    logic [MB*DW-1:0] req_wdata = '0;
    logic             busy;
    logic             done;
    logic             err;
    logic [MB*DW-1:0] rdata;
    logic [DW-1:0]    DATA_in = '0;
    logic [DW-1:0]    DATA_out;
    logic             DATA_oe;
    logic             READY = 1'b0;
    logic [AW-1:0]    ADD;
    logic             S0;
    logic             S1;
    logic             IO_Mn;
    logic             RDn;
    logic             WRn;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    bus_cycle_unit #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_BYTES(MB),
        .WAIT_LIMIT(WL)
    ) dut (
        .clock(clock),
        .reset_in_n(reset_in_n),
        .req(req),
        .req_type(req_type),
        .req_addr(req_addr),
        .req_count(req_count),
        .req_wdata(req_wdata),
        .busy(busy),
        .done(done),
        .err(err),
        .rdata(rdata),
        .DATA_in(DATA_in),
        .DATA_out(DATA_out),
        .DATA_oe(DATA_oe),
        .READY(READY),
        .ADD(ADD),
        .S0(S0),
        .S1(S1),
        .IO_Mn(IO_Mn),
        .RDn(RDn),
        .WRn(WRn)
    );

    // Expands one request into its machine cycles, then steps the DUT
    // through them. Called and returns at a falling edge.
    task automatic run_txn(
        input  string            name,
        input  logic [2:0]       typ,
        input  logic [AW-1:0]    addr,
        input  logic [CW-1:0]    cnt,
        input  logic [MB*DW-1:0] wd,
        input  int               w0,
        input  int               w1,
        input  logic [DW-1:0]    b0,
        input  logic [DW-1:0]    b1,
        input  bit               pulse,
        output logic [MB*DW-1:0] got_rdata,
        output logic             got_err
    );
        int n;
        int k;
        int ph;
        int stray;
        bit wr;
        bit io;
        bit fe;
        bit to;
        logic [1:0] es;
        int qk[$];
        int qp[$];
        bit qr[$];
        int waits[2];
        logic [DW-1:0] bytes[2];
        logic [MB*DW-1:0] er;
        logic [AW-1:0] ea;
        logic [32:0] ev;
        logic [32:0] av;
        logic [23:0] ev2;
        logic [23:0] av2;
        logic [18:0] ev3;
        logic [18:0] av3;

        n = int'(cnt);
        if (n == 0) n = 1;
        if (n > MB) n = MB;
        wr = (typ == 3'd2) || (typ == 3'd4);
        io = (typ == 3'd3) || (typ == 3'd4);
        fe = (typ == 3'd0);
        es = fe ? 2'b11 : (wr ? 2'b01 : 2'b10);
        waits[0] = w0;
        waits[1] = w1;
        bytes[0] = b0;
        bytes[1] = b1;
        to = 1'b0;
        er = '0;
        for (int b = 0; b < n; b++) begin
            if (!to) begin
                qk.push_back(b); qp.push_back(1); qr.push_back(1'b0);
                qk.push_back(b); qp.push_back(2); qr.push_back(1'b0);
                if (waits[b] >= WL) begin
                    for (int j = 0; j < WL; j++) begin
                        qk.push_back(b); qp.push_back(3); qr.push_back(1'b0);
                    end
                    to = 1'b1;
                end else begin
                    for (int j = 0; j < waits[b]; j++) begin
                        qk.push_back(b); qp.push_back(3); qr.push_back(1'b0);
                    end
                    qk.push_back(b); qp.push_back(3); qr.push_back(1'b1);
                    if (!wr) er[b*DW +: DW] = bytes[b];
                end
            end
        end

        req_type  = typ;
        req_addr  = addr;
        req_count = cnt;
        req_wdata = wd;
        req       = 1'b1;
        @(negedge clock);
        for (int i = 0; i < qp.size(); i++) begin
            k  = qk[i];
            ph = qp[i];
            ea = addr + AW'(k);
            ev = {1'b1, 1'b0, 1'b0, ea, es, io,
                  !(ph >= 2 && !wr), !(ph >= 2 && wr), wr,
                  wr ? wd[k*DW +: DW] : 8'h00};
            av = {busy, done, err, ADD, S1, S0, IO_Mn, RDn, WRn,
                  DATA_oe, DATA_oe ? DATA_out : 8'h00};
            checks++;
            if (av !== ev) begin
                failures++;
                $display("FAIL %s cyc%0d T%0d: got %h want %h",
                         name, i, ph, av, ev);
            end
            READY   = (ph == 3) ? qr[i] : 1'($urandom);
            DATA_in = (ph == 3) ? bytes[k] : 8'($urandom);
            req     = pulse ? 1'($urandom) : 1'b0;
            req_type  = 3'($urandom);
            req_addr  = 16'($urandom);
            req_count = 2'($urandom);
            req_wdata = 16'($urandom);
            @(negedge clock);
        end

        ev2 = {1'b1, 1'b1, to, 2'b00, 1'b1, 1'b1, 1'b0, er};
        av2 = {busy, done, err, S1, S0, RDn, WRn, DATA_oe, rdata};
        checks++;
        if (av2 !== ev2) begin
            failures++;
            $display("FAIL %s end: got %h want %h", name, av2, ev2);
        end
        req = 1'b0;
        @(negedge clock);
        ev3 = {1'b0, 1'b0, to, er};
        av3 = {busy, done, err, rdata};
        checks++;
        if (av3 !== ev3) begin
            failures++;
            $display("FAIL %s idle: got %h want %h", name, av3, ev3);
        end
        got_rdata = rdata;
        got_err   = err;
        if (pulse) begin
            stray = 0;
            repeat (4) begin
                @(negedge clock);
                if (busy || done) stray++;
            end
            checks++;
            if (stray != 0) begin
                failures++;
                $display("FAIL %s queued_req: got %0d busy/done cycles want 0",
                         name, stray);
            end
        end
    endtask

    task automatic test_reset();
        logic [46:0] av;
        logic [46:0] ev;
        reset_in_n = 1'b0;
        req        = 1'b1;
        READY      = 1'b1;
        repeat (3) @(negedge clock);
        ev = {16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00,
              1'b0, 1'b0, 1'b0, 16'h0000};
        av = {ADD, S1, S0, IO_Mn, RDn, WRn, DATA_oe, DATA_out,
              busy, done, err, rdata};
        checks++;
        if (av !== ev) begin
            failures++;
            $display("FAIL reset_state: got %h want %h", av, ev);
        end
        req        = 1'b0;
        reset_in_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_fetch();
        logic [MB*DW-1:0] rd;
        logic e;
        run_txn("fetch", 3'd0, 16'h0100, 2'd1, 16'h0000, 0, 0,
                8'h3A, 8'h00, 1'b0, rd, e);
        checks++;
        if ({e, rd} !== {1'b0, 16'h003A}) begin
            failures++;
            $display("FAIL fetch_data: got %h want %h", {e, rd}, 17'h0003A);
        end
    endtask

    task automatic test_mem_read_wait();
        logic [MB*DW-1:0] rd;
        logic e;
        run_txn("memrd2", 3'd1, 16'h2000, 2'd2, 16'h0000, 0, 2,
                8'h34, 8'h12, 1'b0, rd, e);
        checks++;
        if (rd !== 16'h1234) begin
            failures++;
            $display("FAIL memrd2_data: got %h want 1234", rd);
        end
    endtask

    task automatic test_writes();
        logic [MB*DW-1:0] rd;
        logic e;
        run_txn("iowr", 3'd4, 16'h0042, 2'd1, 16'h005A, 0, 0,
                8'h00, 8'h00, 1'b0, rd, e);
        run_txn("memwr_wrap", 3'd2, 16'hFFFF, 2'd2, 16'hBEEF, 1, 0,
                8'h00, 8'h00, 1'b0, rd, e);
    endtask

    task automatic test_timeout();
        logic [MB*DW-1:0] rd;
        logic e;
        run_txn("timeout_b0", 3'd1, 16'h3000, 2'd2, 16'h0000, 6, 0,
                8'h11, 8'h22, 1'b0, rd, e);
        checks++;
        if ({e, rd} !== {1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL timeout_b0_result: got %h want 10000", {e, rd});
        end
        run_txn("timeout_b1", 3'd3, 16'h0080, 2'd2, 16'h0000, 0, 4,
                8'hAB, 8'hCD, 1'b0, rd, e);
        checks++;
        if ({e, rd} !== {1'b1, 16'h00AB}) begin
            failures++;
            $display("FAIL timeout_b1_result: got %h want 100ab", {e, rd});
        end
        run_txn("after_timeout", 3'd1, 16'h0081, 2'd1, 16'h0000, 3, 0,
                8'h77, 8'h00, 1'b0, rd, e);
    endtask

    task automatic test_count_clamp();
        logic [MB*DW-1:0] rd;
        logic e;
        run_txn("count0", 3'd1, 16'h1000, 2'd0, 16'h0000, 0, 0,
                8'h5C, 8'h99, 1'b0, rd, e);
        run_txn("count3", 3'd6, 16'h1000, 2'd3, 16'h0000, 0, 1,
                8'hC5, 8'h6D, 1'b0, rd, e);
    endtask

    task automatic test_reset_abort();
        int stray;
        req_type  = 3'd2;
        req_addr  = 16'h1234;
        req_count = 2'd1;
        req_wdata = 16'h00C3;
        READY     = 1'b0;
        req       = 1'b1;
        @(negedge clock);
        req = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({WRn, DATA_oe, busy, DATA_out} !== {3'b011, 8'hC3}) begin
            failures++;
            $display("FAIL abort_pre: got %h want 3c3",
                     {WRn, DATA_oe, busy, DATA_out});
        end
        reset_in_n = 1'b0;
        @(negedge clock);
        checks++;
        if ({WRn, DATA_oe, busy, done} !== 4'b1000) begin
            failures++;
            $display("FAIL abort_post: got %b want 1000",
                     {WRn, DATA_oe, busy, done});
        end
        reset_in_n = 1'b1;
        READY      = 1'b1;
        stray      = 0;
        repeat (6) begin
            @(negedge clock);
            if (done || busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d cycles want 0", stray);
        end
    endtask

    task automatic test_busy_req();
        logic [MB*DW-1:0] rd;
        logic e;
        run_txn("busy_req", 3'd1, 16'h4000, 2'd2, 16'h0000, 1, 1,
                8'h0F, 8'hF0, 1'b1, rd, e);
    endtask

    task automatic test_random();
        logic [MB*DW-1:0] rd;
        logic e;
        int w[2];
        for (int t = 0; t < 40; t++) begin
            for (int b = 0; b < 2; b++) begin
                w[b] = ($urandom_range(0, 7) == 0) ?
                       WL + int'($urandom_range(0, 2)) :
                       int'($urandom_range(0, 3));
            end
            run_txn("random", 3'($urandom), 16'($urandom), 2'($urandom),
                    16'($urandom), w[0], w[1], 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0), rd, e);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_fetch();
        test_mem_read_wait();
        test_writes();
        test_timeout();
        test_count_clamp();
        test_reset_abort();
        test_busy_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_cycle_unit.md
Name: bus_cycle_unit

Overview:
- Parametrised 8080/8085-style bus interface unit for a CPU core.
- Accepts one transfer request per transaction: opcode fetch, memory read/write or I/O read/write.
- Runs 1..MAX_BYTES back-to-back T1/T2/T3 machine cycles at consecutive addresses, with READY-driven wait states and an optional wait timeout.
- Sits between the CPU sequencer and the external bus. The sequencer no longer generates strobes or status itself.

Parameters:
- ADDR_W, 16: address width.
- DATA_W, 8: bus data width.
- MAX_BYTES, 2: maximum machine cycles per request.
- WAIT_LIMIT, 0: maximum wait cycles per machine cycle; 0 means unlimited.

Ports:
- clock  in  1  system clock; all updates on rising edge.
- reset_in_n  in  1  synchronous, active-low reset.
- req  in  1  start request; sampled only in IDLE.
- req_type  in  3  0 = fetch, 1 = mem read, 2 = mem write, 3 = io read, 4 = io write; others treated as mem read.
- req_addr  in  ADDR_W  address of first byte.
- req_count  in  clog2(MAX_BYTES)+1  number of bytes.
- req_wdata  in  MAX_BYTES*DATA_W  write bytes, byte 0 in LSBs.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = wait timeout.
- rdata  out  MAX_BYTES*DATA_W  read bytes, byte k at [k*DATA_W +: DATA_W].
- DATA_in  in  DATA_W  bus data in.
- DATA_out  out  DATA_W  bus data out.
- DATA_oe  out  1  bus data drive enable.
- READY  in  1  memory/IO ready.
- ADD  out  ADDR_W  bus address.
- S0  out  1  status bit 0.
- S1  out  1  status bit 1.
- IO_Mn  out  1  1 = I/O cycle, 0 = memory cycle.
- RDn  out  1  read strobe, active low.
- WRn  out  1  write strobe, active low.

Behaviour:
- Reset (reset_in_n = 0 at an edge): state IDLE; ADD = 0; S1 = S0 = 0; IO_Mn = 0; RDn = WRn = 1; DATA_oe = 0; DATA_out = 0; busy = done = err = 0; rdata = 0; byte and wait counters = 0.
- Reset mid-transaction: abort at that edge with the same values and no done pulse.
- States: IDLE, T1, T2, T3, END.
- IDLE, req = 1 at an edge:
  - Latch type, address and wdata.
  - Latch count: 0 becomes 1; values above MAX_BYTES clamp to MAX_BYTES.
  - Clear rdata; busy = 1; next state T1.
- req in any other state is ignored and not queued.
- T1:
  - ADD = base + byte index, modulo 2^ADDR_W (FFFF+1 wraps to 0000).
  - Status: fetch S1S0 = 11; read S1S0 = 10; write S1S0 = 01.
  - IO_Mn = 1 for io types.
  - For writes: DATA_out = current byte and DATA_oe = 1, held through T3.
- T2: RDn = 0 for fetch/read types, or WRn = 0 for write types. Next state T3.
- T3, READY = 0:
  - Stay in T3 with the strobe held; wait counter increments.
  - If WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT: deassert the strobe, clear DATA_oe, set err = 1, go to END. Remaining bytes are skipped; rdata keeps bytes already captured.
- T3, READY = 1:
  - For reads, capture DATA_in into rdata byte k.
  - Deassert the strobe, clear DATA_oe, reset the wait counter.
  - If more bytes remain, go to T1 with k+1; otherwise go to END.
- END:
  - done = 1 for exactly one cycle; S1S0 = 00; busy = 0 from next cycle; next state IDLE.
  - err holds until the next accept.
  - rdata holds until the next accept.
- Latency, zero waits: req at edge n gives T1 at n+1 and done at n+1+3*count. Each wait cycle adds 1.
- RDn and WRn are never low together. Strobes are only low in T2/T3.

Test Plan:
- Fetch at 0x0100, count 1, READY = 1, DATA_in = 0x3A:
  - T1 ADD = 0100 with S1S0 = 11; RDn low for T2–T3.
  - rdata[7:0] = 3A; done 4 cycles after req; err = 0.
- Mem read at 0x2000, count 2, READY low for 2 cycles in the second T3, bytes 0x34 then 0x12:
  - ADD 2000 then 2001; rdata = 0x1234; done 9 cycles after req.
- IO write at 0x0042, wdata 0x5A:
  - IO_Mn = 1; S1S0 = 01; DATA_oe = 1 and DATA_out = 5A through T1–T3; WRn low T2–T3; RDn stays 1.
- Mem write at 0xFFFF, count 2, wdata 0xBEEF:
  - Byte EF at FFFF, byte BE at 0000.
- WAIT_LIMIT = 4, READY held 0:
  - RDn rises after 4 wait cycles; done = 1 and err = 1; second byte never issued.
- Drop reset_in_n during T3 of a write:
  - Next cycle WRn = 1, DATA_oe = 0, busy = 0, and no done pulse.
- req pulsed while busy:
  - No effect; transaction count unchanged.
